// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Owns the PC and keeps one instruction-memory fetch outstanding at a time.
// Returned words go into a small queue, and the head word is presented as Inst/PCAdd4.
// Stall holds the head word in place.
// Redirect flushes the queue, moves the PC, and kills any fetch still in flight.
// Optional build macro IF_PERF_CNT_EN adds the bubble_cnt and redirect_cnt counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Inst,
    output logic [31:0] PCAdd4,
    output logic        IFFlush
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] redirect_cnt
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // IDLE: nothing outstanding, BUSY: outstanding and wanted, KILL: outstanding but wrong-path
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        KILL = 2'd2
    } fsm_t;

    fsm_t          state, state_nxt;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   q_inst [FIFO_DEPTH];
    logic [31:0]   q_pc   [FIFO_DEPTH];

    logic head_vld;
    logic pop;
    logic push;
    logic issue;
    logic room;

    assign head_vld = (count != '0);
    // A pop this cycle frees a slot, so a full queue that is draining may still issue
    assign room     = (count < DEPTH_C) | pop;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next state; a redirect without ack turns the in-flight fetch into a kill
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue)    state_nxt = BUSY;
            BUSY:    if (imem_ack) state_nxt = IDLE;
                     else if (redirect) state_nxt = KILL;
            KILL:    if (imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: issue/pop/push decisions; redirect blocks all three
    always_comb begin
        pop   = head_vld & ~stall & ~redirect;
        issue = ~rst & (state == IDLE) & ~redirect & room;
        push  = (state == BUSY) & imem_ack & ~redirect;
    end

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign IFFlush   = redirect;
    assign Inst      = head_vld ? q_inst[rd_ptr] : 32'h0;
    assign PCAdd4    = head_vld ? (q_pc[rd_ptr] + 32'd4) : 32'h0;

    // PC and address of the outstanding request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect) begin
            pc     <= redirect_target;
        end else if (issue) begin
            pc     <= pc + 32'd4;
            req_pc <= pc;
        end
    end

    // Queue pointers and occupancy; redirect empties the queue outright
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Queue storage holds data only, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters: bubble cycles and redirect cycles, free-running with wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt   <= 32'h0;
            redirect_cnt <= 32'h0;
        end else begin
            if (!head_vld && !stall) bubble_cnt   <= bubble_cnt + 32'd1;
            if (redirect)            redirect_cnt <= redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scenarios followed by a randomized run.
// A memory responder with programmable latency serves the fetch requests.
// A queue-based reference model predicts Inst, PCAdd4, imem_req, imem_addr and IFFlush every cycle.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Inst;
    logic [31:0] PCAdd4;
    logic        IFFlush;
`ifdef IF_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] redirect_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Inst(Inst), .PCAdd4(PCAdd4), .IFFlush(IFFlush)
`ifdef IF_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] w;
    } ent_t;

    // reference model: fetched-but-unconsumed words, next fetch address, in-flight fetch
    ent_t        mq[$];
    logic [31:0] m_pc = RESET_PC;
    logic        m_out = 1'b0;
    logic        m_kill = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_bub = 32'h0;
    logic [31:0] m_red = 32'h0;

    // memory responder
    logic        r_pend = 1'b0;
    int          r_left = 0;
    logic [31:0] r_addr = 32'h0;
    int          lat_v = 1;
    logic        rand_lat = 1'b0;

    // last sampled outputs
    logic        s_req, s_flush;
    logic [31:0] s_addr, s_inst, s_pca4;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B9) | 32'h0000_0001;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick(input logic st, input logic rd, input logic [31:0] tg, input logic rs);
        logic        ack;
        logic [31:0] rdat;
        logic        pop;
        logic        ereq;
        logic [31:0] einst;
        logic [31:0] epca;
        @(negedge clk);
        ack  = 1'b0;
        rdat = $urandom;
        if (r_pend) begin
            r_left--;
            if (r_left == 0) begin
                ack    = 1'b1;
                rdat   = word_at(r_addr);
                r_pend = 1'b0;
            end
        end
        stall           = st;
        redirect        = rd;
        redirect_target = tg;
        rst             = rs;
        imem_ack        = ack;
        imem_rdata      = rdat;
        #1;
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_inst  = Inst;
        s_pca4  = PCAdd4;
        s_flush = IFFlush;
        if (rs) begin
            mq.delete();
            m_pc   = RESET_PC;
            m_out  = 1'b0;
            m_kill = 1'b0;
            m_bub  = 32'h0;
            m_red  = 32'h0;
        end
        einst = (mq.size() != 0) ? mq[0].w : 32'h0;
        epca  = (mq.size() != 0) ? mq[0].a + 32'd4 : 32'h0;
        pop   = (mq.size() != 0) && !st && !rd && !rs;
        ereq  = !rs && !m_out && !rd && ((mq.size() < DEPTH) || pop);
        chk("Inst", s_inst, einst);
        chk("PCAdd4", s_pca4, epca);
        chk("imem_req", {31'b0, s_req}, {31'b0, ereq});
        chk("IFFlush", {31'b0, s_flush}, {31'b0, rd});
        if (ereq && s_req) chk("imem_addr", s_addr, m_pc);
`ifdef IF_PERF_CNT_EN
        chk("bubble_cnt", bubble_cnt, m_bub);
        chk("redirect_cnt", redirect_cnt, m_red);
`endif
        if (s_req) begin
            r_pend = 1'b1;
            r_addr = s_addr;
            r_left = rand_lat ? int'($urandom_range(1, 4)) : lat_v;
        end
        if (!rs) begin
            if (mq.size() == 0 && !st) m_bub++;
            if (rd) m_red++;
            if (rd) begin
                mq.delete();
                m_pc = tg;
                if (m_out) begin
                    if (ack) begin
                        m_out  = 1'b0;
                        m_kill = 1'b0;
                    end else begin
                        m_kill = 1'b1;
                    end
                end
            end else begin
                if (pop) void'(mq.pop_front());
                if (ack && m_out) begin
                    if (!m_kill) mq.push_back('{a: m_addr, w: rdat});
                    m_out  = 1'b0;
                    m_kill = 1'b0;
                end
                if (ereq) begin
                    m_out  = 1'b1;
                    m_addr = m_pc;
                    m_pc   = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic do_reset();
        r_pend = 1'b0;
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_Inst", s_inst, 32'h0);
        chk("rst_req", {31'b0, s_req}, 32'h0);

        // 1: latency 1, fetches every other cycle, bubbles in between
        lat_v = 1;
        tick(0, 0, 0, 0);
        chk("t1_addr0", s_addr, RESET_PC);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("t1_inst0", s_inst, word_at(32'h0));
        chk("t1_pca0", s_pca4, 32'h4);
        chk("t1_addr1", s_addr, 32'h4);
        tick(0, 0, 0, 0);
        chk("t1_gap", s_inst, 32'h0);
        tick(0, 0, 0, 0);
        chk("t1_inst1", s_inst, word_at(32'h4));
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("t1_inst2", s_inst, word_at(32'h8));
        chk("t1_pca2", s_pca4, 32'hC);

        // 2: stall held 4 cycles, fetch stops when full, then drain without gaps
        do_reset();
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("t2_inst_a", s_inst, word_at(32'h0));
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("t2_full_noreq", {31'b0, s_req}, 32'h0);
        tick(1, 0, 0, 0);
        chk("t2_inst_hold", s_inst, word_at(32'h0));
        chk("t2_pca_hold", s_pca4, 32'h4);
        tick(0, 0, 0, 0);
        chk("t2_drain0", s_inst, word_at(32'h0));
        tick(0, 0, 0, 0);
        chk("t2_drain1", s_inst, word_at(32'h4));
        tick(0, 0, 0, 0);
        chk("t2_drain2", s_inst, word_at(32'h8));

        // 3: latency 3, redirect one cycle after request, stale ack discarded
        do_reset();
        lat_v = 3;
        tick(0, 0, 0, 0);
        tick(0, 1, 32'h100, 0);
        chk("t3_flush", {31'b0, s_flush}, 32'h1);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("t3_addr", s_addr, 32'h100);
        chk("t3_req", {31'b0, s_req}, 32'h1);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
        chk("t3_inst", s_inst, word_at(32'h100));
        chk("t3_pca", s_pca4, 32'h104);

        // 4: redirect, ack and stall in the same cycle
        do_reset();
        lat_v = 2;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(1, 1, 32'h200, 0);
        tick(0, 0, 0, 0);
        chk("t4_addr", s_addr, 32'h200);
        chk("t4_inst", s_inst, 32'h0);

        // 5: reset while BUSY, late ack lands in IDLE
        do_reset();
        lat_v = 2;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        chk("t5_addr", s_addr, RESET_PC);
        tick(0, 0, 0, 0);
        chk("t5_ignored", s_inst, 32'h0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("t5_inst", s_inst, word_at(RESET_PC));

        // randomized run against the model
        do_reset();
        rand_lat = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic        st, rd, rs;
            logic [31:0] tg;
            st = ($urandom % 10) < 3;
            rd = ($urandom % 12) == 0;
            tg = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            rs = ($urandom % 500) == 0;
            tick(st, rd, tg, rs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
